pipeline_regs: RTL and testbench



---
 rtl/pipeline_regs.sv | 161 ++++++++++++++++
 tb/tb_pipeline_regs.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_regs.sv
// Pipeline register bank for the 5-stage processor datapath.
// Holds the IF/ID, ID/EX and EX/WB latches. Every output comes straight
// from a flop. Each stage supports synchronous reset, and some stages also
// support flush (bubble insertion) or stall. The all-zero word is the
// bubble encoding everywhere.
module pipeline_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifid_stall,
    input  logic        ifid_flush,
    input  logic        idex_flush,

    // IF/ID
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,

    // ID/EX control
    input  logic        id_branch,
    input  logic        id_jump,
    input  logic        id_jump_mem,
    input  logic        id_mem_read,
    input  logic        id_mem_to_reg,
    input  logic        id_mem_write,
    input  logic        id_alu_src,
    input  logic        id_reg_wrt,
    input  logic        id_svpc,
    input  logic        id_add,
    input  logic        id_sub,
    input  logic        id_inc,
    input  logic        id_neg,

    // ID/EX data
    input  logic [31:0] id_imm,
    input  logic [5:0]  id_rd,
    input  logic [5:0]  id_rs,
    input  logic [5:0]  id_rt,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_pc_x,

    output logic        ex_branch,
    output logic        ex_jump,
    output logic        ex_jump_mem,
    output logic        ex_mem_read,
    output logic        ex_mem_to_reg,
    output logic        ex_mem_write,
    output logic        ex_alu_src,
    output logic        ex_reg_wrt,
    output logic        ex_svpc,
    output logic        ex_add,
    output logic        ex_sub,
    output logic        ex_inc,
    output logic        ex_neg,
    output logic [31:0] ex_imm,
    output logic [5:0]  ex_rd,
    output logic [5:0]  ex_rs,
    output logic [5:0]  ex_rt,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_pc_x,

    // EX/WB
    input  logic        ex_mem_to_reg_in,
    input  logic [31:0] ex_dm_out,
    input  logic [31:0] ex_alu_out,
    input  logic        ex_reg_wrt_in,
    input  logic [5:0]  ex_rd_in,
    input  logic [31:0] ex_sum_out,
    input  logic        ex_svpc_in,

    output logic        wb_mem_to_reg,
    output logic [31:0] wb_dm_data,
    output logic [31:0] wb_alu,
    output logic        wb_reg_wrt,
    output logic [5:0]  wb_rd,
    output logic [31:0] wb_adder,
    output logic        wb_svpc
);

    // IF/ID latch: reset and flush both load the NOP bubble, and flush beats stall
    always_ff @(posedge clk) begin
        if (rst || ifid_flush) begin
            id_pc   <= 32'h0000_0000;
            id_inst <= 32'h0000_0000;
        end else if (!ifid_stall) begin
            id_pc   <= if_pc;
            id_inst <= if_inst;
        end
    end

    // ID/EX latch: reset or flush clears the whole entry (control and data), otherwise load
    always_ff @(posedge clk) begin
        if (rst || idex_flush) begin
            ex_branch     <= 1'b0;
            ex_jump       <= 1'b0;
            ex_jump_mem   <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_reg_wrt    <= 1'b0;
            ex_svpc       <= 1'b0;
            ex_add        <= 1'b0;
            ex_sub        <= 1'b0;
            ex_inc        <= 1'b0;
            ex_neg        <= 1'b0;
            ex_imm        <= 32'h0000_0000;
            ex_rd         <= 6'd0;
            ex_rs         <= 6'd0;
            ex_rt         <= 6'd0;
            ex_rs_data    <= 32'h0000_0000;
            ex_rt_data    <= 32'h0000_0000;
            ex_pc_x       <= 32'h0000_0000;
        end else begin
            ex_branch     <= id_branch;
            ex_jump       <= id_jump;
            ex_jump_mem   <= id_jump_mem;
            ex_mem_read   <= id_mem_read;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_mem_write  <= id_mem_write;
            ex_alu_src    <= id_alu_src;
            ex_reg_wrt    <= id_reg_wrt;
            ex_svpc       <= id_svpc;
            ex_add        <= id_add;
            ex_sub        <= id_sub;
            ex_inc        <= id_inc;
            ex_neg        <= id_neg;
            ex_imm        <= id_imm;
            ex_rd         <= id_rd;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_rs_data    <= id_rs_data;
            ex_rt_data    <= id_rt_data;
            ex_pc_x       <= id_pc_x;
        end
    end

    // EX/WB latch: only reset interrupts the every-cycle load
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_mem_to_reg <= 1'b0;
            wb_dm_data    <= 32'h0000_0000;
            wb_alu        <= 32'h0000_0000;
            wb_reg_wrt    <= 1'b0;
            wb_rd         <= 6'd0;
            wb_adder      <= 32'h0000_0000;
            wb_svpc       <= 1'b0;
        end else begin
            wb_mem_to_reg <= ex_mem_to_reg_in;
            wb_dm_data    <= ex_dm_out;
            wb_alu        <= ex_alu_out;
            wb_reg_wrt    <= ex_reg_wrt_in;
            wb_rd         <= ex_rd_in;
            wb_adder      <= ex_sum_out;
            wb_svpc       <= ex_svpc_in;
        end
    end

endmodule

// File: tb/tb_pipeline_regs.sv
// Self-checking bench for pipeline_regs. Each applied stimulus pushes the
// expected register contents onto a scoreboard queue; after the edge the
// entry is popped and compared field by field against the DUT.
module tb_pipeline_regs;

    // Control bit order: branch jump jumpMem memRead memToReg memWrite
    // aluSrc regWrt svpc add sub inc neg (bit 12 down to bit 0)
    localparam int CTRL_ADD      = 3;
    localparam int CTRL_REG_WRT  = 5;
    localparam int CTRL_MEM_WRITE = 7;

    typedef struct packed {
        logic [31:0] idPc;
        logic [31:0] idInst;
        logic [12:0] exCtrl;
        logic [31:0] exImm;
        logic [5:0]  exRd;
        logic [5:0]  exRs;
        logic [5:0]  exRt;
        logic [31:0] exRsData;
        logic [31:0] exRtData;
        logic [31:0] exPcX;
        logic        wbMemToReg;
        logic [31:0] wbDmData;
        logic [31:0] wbAlu;
        logic        wbRegWrt;
        logic [5:0]  wbRd;
        logic [31:0] wbAdder;
        logic        wbSvpc;
    } regState_t;

    logic        clk = 1'b0;
    logic        rst, ifidStall, ifidFlush, idexFlush;
    logic [31:0] ifPc, ifInst;
    logic [12:0] idCtrl;
    logic [31:0] idImm, idRsData, idRtData, idPcX;
    logic [5:0]  idRd, idRs, idRt;
    logic        exMemToRegIn, exRegWrtIn, exSvpcIn;
    logic [31:0] exDmOut, exAluOut, exSumOut;
    logic [5:0]  exRdIn;

    logic [31:0] idPc, idInst;
    logic [12:0] exCtrl;
    logic [31:0] exImm, exRsData, exRtData, exPcX;
    logic [5:0]  exRd, exRs, exRt;
    logic        wbMemToReg, wbRegWrt, wbSvpc;
    logic [31:0] wbDmData, wbAlu, wbAdder;
    logic [5:0]  wbRd;

    regState_t   model;
    regState_t   scoreboard[$];
    int          totalChecks = 0;
    int          badChecks = 0;

    always #5 clk = ~clk;

    pipeline_regs dut (
        .clk(clk), .rst(rst),
        .ifid_stall(ifidStall), .ifid_flush(ifidFlush), .idex_flush(idexFlush),
        .if_pc(ifPc), .if_inst(ifInst), .id_pc(idPc), .id_inst(idInst),
        .id_branch(idCtrl[12]), .id_jump(idCtrl[11]), .id_jump_mem(idCtrl[10]),
        .id_mem_read(idCtrl[9]), .id_mem_to_reg(idCtrl[8]), .id_mem_write(idCtrl[7]),
        .id_alu_src(idCtrl[6]), .id_reg_wrt(idCtrl[5]), .id_svpc(idCtrl[4]),
        .id_add(idCtrl[3]), .id_sub(idCtrl[2]), .id_inc(idCtrl[1]), .id_neg(idCtrl[0]),
        .id_imm(idImm), .id_rd(idRd), .id_rs(idRs), .id_rt(idRt),
        .id_rs_data(idRsData), .id_rt_data(idRtData), .id_pc_x(idPcX),
        .ex_branch(exCtrl[12]), .ex_jump(exCtrl[11]), .ex_jump_mem(exCtrl[10]),
        .ex_mem_read(exCtrl[9]), .ex_mem_to_reg(exCtrl[8]), .ex_mem_write(exCtrl[7]),
        .ex_alu_src(exCtrl[6]), .ex_reg_wrt(exCtrl[5]), .ex_svpc(exCtrl[4]),
        .ex_add(exCtrl[3]), .ex_sub(exCtrl[2]), .ex_inc(exCtrl[1]), .ex_neg(exCtrl[0]),
        .ex_imm(exImm), .ex_rd(exRd), .ex_rs(exRs), .ex_rt(exRt),
        .ex_rs_data(exRsData), .ex_rt_data(exRtData), .ex_pc_x(exPcX),
        .ex_mem_to_reg_in(exMemToRegIn), .ex_dm_out(exDmOut), .ex_alu_out(exAluOut),
        .ex_reg_wrt_in(exRegWrtIn), .ex_rd_in(exRdIn), .ex_sum_out(exSumOut),
        .ex_svpc_in(exSvpcIn),
        .wb_mem_to_reg(wbMemToReg), .wb_dm_data(wbDmData), .wb_alu(wbAlu),
        .wb_reg_wrt(wbRegWrt), .wb_rd(wbRd), .wb_adder(wbAdder), .wb_svpc(wbSvpc)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Fill every data/control input with random values; flags are left alone
    task automatic randomizeInputs();
        ifPc = $urandom; ifInst = $urandom;
        idCtrl = 13'($urandom); idImm = $urandom;
        idRd = 6'($urandom); idRs = 6'($urandom); idRt = 6'($urandom);
        idRsData = $urandom; idRtData = $urandom; idPcX = $urandom;
        exMemToRegIn = 1'($urandom); exRegWrtIn = 1'($urandom); exSvpcIn = 1'($urandom);
        exDmOut = $urandom; exAluOut = $urandom; exSumOut = $urandom;
        exRdIn = 6'($urandom);
    endtask

    // Reference behaviour for one rising edge given the inputs now driven
    task automatic predictEdge();
        regState_t nxt;
        nxt = model;
        if (rst || ifidFlush) begin
            nxt.idPc = '0; nxt.idInst = '0;
        end else if (!ifidStall) begin
            nxt.idPc = ifPc; nxt.idInst = ifInst;
        end
        if (rst || idexFlush) begin
            nxt.exCtrl = '0; nxt.exImm = '0; nxt.exRd = '0; nxt.exRs = '0; nxt.exRt = '0;
            nxt.exRsData = '0; nxt.exRtData = '0; nxt.exPcX = '0;
        end else begin
            nxt.exCtrl = idCtrl; nxt.exImm = idImm; nxt.exRd = idRd; nxt.exRs = idRs;
            nxt.exRt = idRt; nxt.exRsData = idRsData; nxt.exRtData = idRtData; nxt.exPcX = idPcX;
        end
        if (rst) begin
            nxt.wbMemToReg = 1'b0; nxt.wbDmData = '0; nxt.wbAlu = '0; nxt.wbRegWrt = 1'b0;
            nxt.wbRd = '0; nxt.wbAdder = '0; nxt.wbSvpc = 1'b0;
        end else begin
            nxt.wbMemToReg = exMemToRegIn; nxt.wbDmData = exDmOut; nxt.wbAlu = exAluOut;
            nxt.wbRegWrt = exRegWrtIn; nxt.wbRd = exRdIn; nxt.wbAdder = exSumOut;
            nxt.wbSvpc = exSvpcIn;
        end
        model = nxt;
    endtask

    // Predict, push, clock once, then pop and compare every output field
    task automatic applyStimulus();
        regState_t exp;
        predictEdge();
        scoreboard.push_back(model);
        @(posedge clk);
        #1;
        if (scoreboard.size() == 0) begin
            checkOutput("scoreboardEmpty", 32'd0, 32'd1);
            return;
        end
        exp = scoreboard.pop_front();
        checkOutput("idPc", idPc, exp.idPc);
        checkOutput("idInst", idInst, exp.idInst);
        checkOutput("exCtrl", 32'(exCtrl), 32'(exp.exCtrl));
        checkOutput("exImm", exImm, exp.exImm);
        checkOutput("exRd", 32'(exRd), 32'(exp.exRd));
        checkOutput("exRs", 32'(exRs), 32'(exp.exRs));
        checkOutput("exRt", 32'(exRt), 32'(exp.exRt));
        checkOutput("exRsData", exRsData, exp.exRsData);
        checkOutput("exRtData", exRtData, exp.exRtData);
        checkOutput("exPcX", exPcX, exp.exPcX);
        checkOutput("wbMemToReg", 32'(wbMemToReg), 32'(exp.wbMemToReg));
        checkOutput("wbDmData", wbDmData, exp.wbDmData);
        checkOutput("wbAlu", wbAlu, exp.wbAlu);
        checkOutput("wbRegWrt", 32'(wbRegWrt), 32'(exp.wbRegWrt));
        checkOutput("wbRd", 32'(wbRd), 32'(exp.wbRd));
        checkOutput("wbAdder", wbAdder, exp.wbAdder);
        checkOutput("wbSvpc", 32'(wbSvpc), 32'(exp.wbSvpc));
    endtask

    initial begin
        model = '0;
        rst = 1'b0; ifidStall = 1'b0; ifidFlush = 1'b0; idexFlush = 1'b0;
        randomizeInputs();

        // Reset with every input nonzero and competing flags asserted
        ifPc = 32'hFFFF_FFFF; ifInst = 32'hFFFF_FFFF; idCtrl = '1; idRd = 6'd63;
        exRdIn = 6'd63; exRegWrtIn = 1'b1;
        rst = 1'b1; ifidStall = 1'b1;
        applyStimulus();
        checkOutput("resetInst", idInst, 32'h0);
        checkOutput("resetWbRd", 32'(wbRd), 32'h0);
        rst = 1'b0; ifidStall = 1'b0;

        // Directed pass-through
        randomizeInputs();
        ifPc = 32'h0000_0010; ifInst = 32'hA5A5_0F0F;
        idRd = 6'd63; idImm = 32'hFFFF_FFFE; idCtrl = '0; idCtrl[CTRL_ADD] = 1'b1;
        applyStimulus();
        checkOutput("passIdPc", idPc, 32'h10);
        checkOutput("passExRd", 32'(exRd), 32'd63);
        checkOutput("passExAdd", 32'(exCtrl[CTRL_ADD]), 32'd1);

        // Stall for three edges, then release
        ifInst = 32'h1111_1111;
        applyStimulus();
        ifInst = 32'h2222_2222; ifidStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ifPc = $urandom;
            applyStimulus();
            checkOutput("stallHold", idInst, 32'h1111_1111);
        end
        ifidStall = 1'b0;
        applyStimulus();
        checkOutput("stallRelease", idInst, 32'h2222_2222);

        // Flush priority over stall, and ID/EX flush killing write controls
        ifInst = 32'hDEAD_BEEF; ifidFlush = 1'b1; ifidStall = 1'b1;
        idexFlush = 1'b1; idCtrl = '1; idCtrl[CTRL_REG_WRT] = 1'b1; idCtrl[CTRL_MEM_WRITE] = 1'b1;
        applyStimulus();
        checkOutput("flushInst", idInst, 32'h0);
        checkOutput("flushRegWrt", 32'(exCtrl[CTRL_REG_WRT]), 32'd0);
        checkOutput("flushMemWrite", 32'(exCtrl[CTRL_MEM_WRITE]), 32'd0);
        ifidFlush = 1'b0; ifidStall = 1'b0; idexFlush = 1'b0;

        // EX/WB capture
        exDmOut = 32'h1234_5678; exAluOut = 32'h9ABC_DEF0; exSumOut = 32'h0000_0044;
        exRdIn = 6'd5; exRegWrtIn = 1'b1; exSvpcIn = 1'b1; exMemToRegIn = 1'b0;
        applyStimulus();
        checkOutput("capWbDm", wbDmData, 32'h1234_5678);
        checkOutput("capWbRd", 32'(wbRd), 32'd5);

        // Mid-stream reset on the third of four instructions
        for (int i = 0; i < 4; i++) begin
            randomizeInputs();
            ifInst = 32'hC000_0000 + 32'(i);
            rst = (i == 2);
            applyStimulus();
            if (i == 2) checkOutput("midRstInst", idInst, 32'h0);
        end
        checkOutput("resumeInst", idInst, 32'hC000_0003);

        // Random traffic with occasional flags
        for (int i = 0; i < 300; i++) begin
            randomizeInputs();
            ifidStall = ($urandom_range(3) == 0);
            ifidFlush = ($urandom_range(7) == 0);
            idexFlush = ($urandom_range(7) == 0);
            rst = ($urandom_range(31) == 0);
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
